// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access-size codes, result-select values,
// the handshake FSM states and the MEM/WB register layout.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_fault;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational load/store lane logic: byte enables, store-data replication,
// load-data extraction/extension and the misaligned/illegal access flag.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        fault_o
);

  logic [31:0] lane;
  logic        bad;

  // Shift the addressed byte/half down to bit 0; for aligned words this is the word.
  assign lane = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    be_o        = 4'b1111;
    wdata_o     = wdata_i;
    load_data_o = '0;
    bad         = 1'b0;
    case (funct3_i)
      F3_B: begin
        if (is_store_i) be_o = 4'b0001 << addr_lo_i;
        wdata_o     = {4{wdata_i[7:0]}};
        load_data_o = {{24{lane[7]}}, lane[7:0]};
      end
      F3_H: begin
        if (is_store_i) be_o = 4'b0011 << addr_lo_i;
        wdata_o     = {2{wdata_i[15:0]}};
        load_data_o = {{16{lane[15]}}, lane[15:0]};
        bad         = addr_lo_i[0];
      end
      F3_W: begin
        load_data_o = lane;
        bad         = (addr_lo_i != 2'b00);
      end
      F3_BU: begin
        load_data_o = {24'h0, lane[7:0]};
        bad         = is_store_i;
      end
      F3_HU: begin
        load_data_o = {16'h0, lane[15:0]};
        bad         = is_store_i | addr_lo_i[0];
      end
      default: bad = 1'b1;
    endcase
    fault_o = (is_load_i | is_store_i) & bad;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the data-memory ready/handshake bus, stalls upstream while
// memory is busy, and holds the MEM/WB register feeding writeback.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [4:0]      RdM,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      Funct3M,
  output logic            DMemReq,
  output logic            DMemWe,
  output logic [XLEN-1:0] DMemAddr,
  output logic [XLEN-1:0] DMemWData,
  output logic [3:0]      DMemBe,
  input  logic            DMemReady,
  input  logic [XLEN-1:0] DMemRData,
  output logic            StallM,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [4:0]      RdW,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic            MemFaultW
);

  state_e      state_q, state_d;
  wb_t         wb_q, wb_d;
  bus_t        bus_q, bus_cur, bus_sel;
  logic        is_store, is_load, fault, legal;
  logic        req, stall;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;
  wb_t         wb_m, wb_done;

  assign is_store = MemWriteM;
  assign is_load  = !MemWriteM && (ResultSrcM == RES_LOAD);
  assign legal    = (is_store | is_load) & ~fault;

  lsu_align u_align (
    .funct3_i    (Funct3M),
    .addr_lo_i   (ALUResultM[1:0]),
    .is_load_i   (is_load),
    .is_store_i  (is_store),
    .wdata_i     (WriteDataM),
    .rdata_i     (DMemRData),
    .be_o        (be),
    .wdata_o     (wdata),
    .load_data_o (load_data),
    .fault_o     (fault)
  );

  assign bus_cur = '{we: is_store, addr: {ALUResultM[31:2], 2'b00}, be: be, wdata: wdata};

  always_comb begin
    wb_m = '{alu_result: ALUResultM, read_data: '0, pc_plus4: PCPlus4M, rd: RdM,
             reg_write: RegWriteM, result_src: ResultSrcM, mem_fault: 1'b0};
    wb_done           = wb_m;
    wb_done.read_data = is_load ? load_data : '0;
  end

  always_comb begin
    state_d = state_q;
    wb_d    = '0;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (legal) begin
          req = 1'b1;
          if (DMemReady) begin
            wb_d = wb_done;
          end else begin
            stall   = 1'b1;
            state_d = S_WAIT;
          end
        end else begin
          wb_d           = wb_m;
          wb_d.reg_write = RegWriteM & ~fault;
          wb_d.mem_fault = fault;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (DMemReady) begin
          wb_d    = wb_done;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gating with rst keeps the request and stall low for the whole reset, not just after the edge.
  assign DMemReq   = rst & req;
  assign StallM    = rst & stall;
  assign bus_sel   = (state_q == S_WAIT) ? bus_q : bus_cur;
  assign DMemWe    = DMemReq & bus_sel.we;
  assign DMemBe    = DMemReq ? bus_sel.be : 4'b0000;
  assign DMemAddr  = bus_sel.addr;
  assign DMemWData = bus_sel.wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wb_q    <= '0;
      bus_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      wb_q    <= wb_d;
      if (state_q == S_IDLE) bus_q <= bus_cur;
    end
  end

  assign ALUResultW = wb_q.alu_result;
  assign ReadDataW  = wb_q.read_data;
  assign PCPlus4W   = wb_q.pc_plus4;
  assign RdW        = wb_q.rd;
  assign RegWriteW  = wb_q.reg_write;
  assign ResultSrcW = wb_q.result_src;
  assign MemFaultW  = wb_q.mem_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model of the
// MEM-stage rules, plus the directed scenarios called out for this block.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic        DMemReq, DMemWe, DMemReady, StallM;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]  DMemBe;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW, MemFaultW;
  logic [1:0]  ResultSrcW;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] alu, rdata, pc4;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  rs;
    logic        f;
  } w_t;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .DMemBe(DMemBe), .DMemReady(DMemReady),
    .DMemRData(DMemRData), .StallM(StallM),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .MemFaultW(MemFaultW)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_w(input w_t e);
    check("ALUResultW", ALUResultW, e.alu);
    check("ReadDataW", ReadDataW, e.rdata);
    check("PCPlus4W", PCPlus4W, e.pc4);
    check("RdW", {27'h0, RdW}, {27'h0, e.rd});
    check("RegWriteW", {31'h0, RegWriteW}, {31'h0, e.rw});
    check("ResultSrcW", {30'h0, ResultSrcW}, {30'h0, e.rs});
    check("MemFaultW", {31'h0, MemFaultW}, {31'h0, e.f});
  endtask

  task automatic drive_m(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic rw, input logic mw,
                         input logic [1:0] rs, input logic [2:0] f3);
    ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RdM = rd;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Funct3M = f3;
  endtask

  // Expected load value: move the addressed lane to bit 0, then extend by size/sign.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] b, h;
    sh = rd >> (8 * off);
    b  = sh & 32'hFF;
    h  = sh & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  // Applies the currently driven M fields as one transaction. Starts and ends just after a negedge.
  task automatic run_txn(input int waits, input logic [31:0] rdata_fin);
    int          off, nbytes;
    logic        access, is_ld, legal_f3, mis, fault, legal;
    logic [31:0] exp_be, exp_wd;
    w_t          e, bubble;
    off      = int'(ALUResultM & 32'h3);
    access   = MemWriteM || (ResultSrcM == 2'b01);
    is_ld    = !MemWriteM && (ResultSrcM == 2'b01);
    legal_f3 = MemWriteM ? (Funct3M <= 3'd2)
                         : (Funct3M inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nbytes   = 1 << int'(Funct3M & 3'd3);
    mis      = (nbytes == 2 && (off % 2) != 0) || (nbytes == 4 && off != 0);
    fault    = access && (!legal_f3 || mis);
    legal    = access && !fault;
    exp_be   = MemWriteM ? ((((32'd1 << nbytes) - 1) << off) & 32'hF) : 32'hF;
    exp_wd   = (nbytes == 1) ? (WriteDataM & 32'hFF) * 32'h0101_0101 :
               (nbytes == 2) ? (WriteDataM & 32'hFFFF) * 32'h0001_0001 : WriteDataM;
    e        = '{alu: ALUResultM, rdata: 32'h0, pc4: PCPlus4M, rd: RdM,
                 rw: RegWriteM, rs: ResultSrcM, f: 1'b0};
    bubble   = '{alu: 32'h0, rdata: 32'h0, pc4: 32'h0, rd: 5'h0, rw: 1'b0, rs: 2'h0, f: 1'b0};
    if (!legal) begin
      DMemReady = 1'($urandom_range(0, 1));
      DMemRData = $urandom;
      #1;
      check("DMemReq idle", {31'h0, DMemReq}, 32'h0);
      check("StallM idle", {31'h0, StallM}, 32'h0);
      @(posedge clk); #1;
      e.f  = fault;
      e.rw = fault ? 1'b0 : RegWriteM;
      check_w(e);
      @(negedge clk);
    end else begin
      for (int i = 0; i <= waits; i++) begin
        DMemReady = (i == waits);
        DMemRData = (i == waits) ? rdata_fin : $urandom;
        #1;
        check("DMemReq", {31'h0, DMemReq}, 32'h1);
        check("StallM", {31'h0, StallM}, {31'h0, !DMemReady});
        check("DMemAddr", DMemAddr, ALUResultM & 32'hFFFF_FFFC);
        check("DMemWe", {31'h0, DMemWe}, {31'h0, MemWriteM});
        check("DMemBe", {28'h0, DMemBe}, exp_be);
        if (MemWriteM) check("DMemWData", DMemWData, exp_wd);
        @(posedge clk); #1;
        if (i == waits) begin
          e.rdata = is_ld ? model_load(Funct3M, off, rdata_fin) : 32'h0;
          check_w(e);
        end else begin
          check_w(bubble);
        end
        @(negedge clk);
      end
    end
    DMemReady = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    DMemReady = 1'b0;
    DMemRData = 32'h0;
    drive_m(32'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 2'b00, 3'b000);
    repeat (2) @(negedge clk);
    check("reset DMemReq", {31'h0, DMemReq}, 32'h0);
    check("reset RegWriteW", {31'h0, RegWriteW}, 32'h0);
    check("reset ALUResultW", ALUResultW, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    drive_m(32'h100, 32'h0, 32'h8, 5'd3, 1'b1, 1'b0, 2'b01, 3'b010);
    run_txn(0, 32'hDEAD_BEEF);
    check("LW ReadDataW", ReadDataW, 32'hDEAD_BEEF);
    check("LW ResultSrcW", {30'h0, ResultSrcW}, 32'h1);

    drive_m(32'h203, 32'h0, 32'hC, 5'd4, 1'b1, 1'b0, 2'b01, 3'b000);
    run_txn(2, 32'h8012_3456);
    check("LB sext", ReadDataW, 32'hFFFF_FF80);
    drive_m(32'h203, 32'h0, 32'hC, 5'd4, 1'b1, 1'b0, 2'b01, 3'b100);
    run_txn(1, 32'h8012_3456);
    check("LBU zext", ReadDataW, 32'h0000_0080);

    drive_m(32'h302, 32'h1234_ABCD, 32'h10, 5'd0, 1'b0, 1'b1, 2'b00, 3'b001);
    DMemReady = 1'b1;
    #1;
    check("SH DMemBe", {28'h0, DMemBe}, 32'hC);
    check("SH DMemWData", DMemWData, 32'hABCD_ABCD);
    @(negedge clk);
    run_txn(0, 32'h0);

    drive_m(32'h101, 32'h0, 32'h14, 5'd6, 1'b1, 1'b0, 2'b01, 3'b010);
    run_txn(0, 32'h0);
    check("LW misaligned fault", {31'h0, MemFaultW}, 32'h1);
    drive_m(32'h0, 32'h0, 32'h44, 5'd1, 1'b1, 1'b0, 2'b10, 3'b000);
    run_txn(0, 32'h0);
    check("fault one cycle", {31'h0, MemFaultW}, 32'h0);
    check("JAL PCPlus4W", PCPlus4W, 32'h44);

    // Reset in the middle of a stalled load.
    drive_m(32'h400, 32'h0, 32'h18, 5'd7, 1'b1, 1'b0, 2'b01, 3'b010);
    DMemReady = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
    check("WAIT StallM", {31'h0, StallM}, 32'h1);
    rst = 1'b0;
    #1;
    check("rst DMemReq", {31'h0, DMemReq}, 32'h0);
    check("rst StallM", {31'h0, StallM}, 32'h0);
    check_w('{alu: 32'h0, rdata: 32'h0, pc4: 32'h0, rd: 5'h0, rw: 1'b0, rs: 2'h0, f: 1'b0});
    @(negedge clk);
    rst = 1'b1;
    drive_m(32'h7, 32'h0, 32'h20, 5'd5, 1'b1, 1'b0, 2'b00, 3'b000);
    run_txn(0, 32'h0);
    check("post-reset ALUResultW", ALUResultW, 32'h7);
    check("post-reset RdW", {27'h0, RdW}, 32'h5);

    for (int n = 0; n < 400; n++) begin
      logic mw;
      logic [1:0] rs;
      mw = ($urandom_range(0, 2) == 0);
      rs = mw ? 2'b00 : 2'($urandom_range(0, 3));
      drive_m($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), mw, rs, 3'($urandom));
      run_txn($urandom_range(0, 3), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
